m68k_bus_slave: RTL
===================

M68K_BUS_SLAVE -- requirements
Module: m68k_bus_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000, window base byte address.
REQ-002 SHALL have parameter ADDR_MASK, default 24'hFF0000, address bits compared against BASE_ADDR.
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra clocks inserted between mem_ack and DTACK assertion.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, clocks from access start to bus-error assertion.
REQ-005 SHALL have the following ports (name direction width meaning): C100 in 1 system clock; reset in 1 synchronous active-high reset.
REQ-006 SHALL have bus-side ports: as_n in 1 address strobe; rw_n in 1 read=1/write=0; uds_n in 1 upper strobe; lds_n in 1 lower strobe; fc in 3 function code; addr in 23 A23..A1; d_in in 16 bus data in.
REQ-007 SHALL have bus-side outputs: d_out out 16 read data; d_oe out 1 data drive enable; dtack_n out 1 transfer ack; berr_n out 1 bus error.
REQ-008 SHALL have local-memory ports: mem_req out 1; mem_we out 1; mem_addr out 23; mem_be out 2 {upper,lower}; mem_wdata out 16; mem_rdata in 16; mem_ack in 1.

Function
REQ-009 SHALL pass as_n, uds_n, lds_n and rw_n through two-flop synchronizers on C100 before use; addr, fc and d_in are sampled only after synchronized strobes qualify them.
REQ-010 SHALL implement states IDLE, DECODE, ACCESS, WAIT, ACK, BERR.
REQ-011 IDLE -> DECODE when synchronized AS low and at least one data strobe low.
REQ-012 DECODE: if ({addr,1'b0} & ADDR_MASK) == BASE_ADDR, latch addr, rw, strobes, d_in; assert mem_req; go to ACCESS; otherwise return to IDLE without driving anything (the access is not ours).
REQ-013 mem_req SHALL stay high until the cycle mem_ack is sampled high, then deassert the next cycle; mem_we = ~rw; mem_be = {~uds,~lds}; mem_wdata = latched d_in.
REQ-014 On read mem_ack, d_out SHALL capture mem_rdata and d_oe SHALL assert in that same cycle; d_oe is never high on a write.
REQ-015 ACCESS -> WAIT on mem_ack; WAIT counts WAIT_STATES clocks (WAIT_STATES=0 bypasses WAIT) then -> ACK.
REQ-016 ACK: dtack_n low; held until synchronized AS high; then dtack_n high, d_oe low, -> IDLE the same cycle.
REQ-017 If AS deasserts during DECODE, ACCESS or WAIT, the block SHALL abort to IDLE, drop mem_req, and never assert dtack_n; an in-flight mem_ack arriving later is ignored.
REQ-018 dtack_n and berr_n SHALL never be low simultaneously.
REQ-019 A new access SHALL not be accepted until AS is observed high for at least one synchronized clock after the previous one.

Reset
REQ-020 On reset high at a C100 edge: state IDLE, dtack_n=1, berr_n=1, d_oe=0, d_out=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counters 0, synchronizer flops set to 1 (inactive).
REQ-021 Reset mid-access SHALL take effect in one clock regardless of state; mem_req drops immediately.

Configuration
REQ-022 With macro M68K_BUS_SLAVE_BERR_TIMEOUT_EN defined: a counter starts in DECODE-hit, and if it reaches TIMEOUT_CYCLES before ACK, the block SHALL go to BERR, drop mem_req, drive berr_n low until AS high, then -> IDLE.
REQ-023 Without the macro: no timeout counter is built, berr_n is tied high, and ACCESS waits on mem_ack indefinitely.

Structure
REQ-024 State encoding and the strobe/byte-enable helpers SHALL live in shared package m68k_bus_pkg, reused by the CPU-side bus model.
REQ-025 The two-flop synchronizer SHALL be a sub-module m68k_sync2 instantiated per strobe.

Verification
REQ-026 Word read at 24'h000100, mem_ack after 3 clocks, mem_rdata=16'hBEEF -> d_out=16'hBEEF, dtack_n low exactly WAIT_STATES clocks after mem_ack, released the cycle after AS high.
REQ-027 Byte write (lds_n low, uds_n high) at 24'h000201, d_in=16'h0055 -> mem_we=1, mem_be=2'b01, mem_wdata=16'h0055, mem_addr=23'h000100.
REQ-028 Access at 24'h100000 (outside window) -> mem_req, dtack_n, d_oe all stay inactive throughout.
REQ-029 mem_ack never arrives, macro defined, TIMEOUT_CYCLES=255 -> berr_n low 255 clocks after access start, dtack_n stays high; macro undefined -> berr_n stays high.
REQ-030 AS raised during ACCESS, then late mem_ack -> no dtack_n pulse; next access completes normally.
REQ-031 reset asserted in ACK state -> next clock dtack_n=1, d_oe=0, state IDLE.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared 68000 bus definitions: slave state encoding and strobe/byte-enable helpers.
// Used by the bus slave and by the CPU-side bus model.
package m68k_bus_pkg;

  localparam int unsigned ADDR_W      = 23;  // A23..A1
  localparam int unsigned BYTE_ADDR_W = 24;  // full byte address
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FC_W        = 3;
  localparam int unsigned BE_W        = 2;   // {upper, lower}

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } bus_state_t;

  // True when at least one data strobe is active (active-low strobes).
  function automatic logic any_strobe(input logic uds_n, input logic lds_n);
    return ~(uds_n & lds_n);
  endfunction

  // Active-low data strobes to active-high byte enables {upper, lower}.
  function automatic logic [BE_W-1:0] strobe_be(input logic uds_n, input logic lds_n);
    return {~uds_n, ~lds_n};
  endfunction

  // Window match on the reconstructed byte address.
  function automatic logic addr_hit(input logic [ADDR_W-1:0]      addr,
                                    input logic [BYTE_ADDR_W-1:0] base,
                                    input logic [BYTE_ADDR_W-1:0] mask);
    return (({addr, 1'b0} & mask) == base);
  endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer for one asynchronous bus strobe.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
// Both flops reset to RST_VAL so strobes read as inactive after reset.
module m68k_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m68k_bus_slave.sv
// 68000 asynchronous-bus slave bridging a decoded address window to a local
// req/ack memory port.
// Ports: C100/reset (clock, sync active-high reset); bus side as_n, rw_n,
// uds_n, lds_n, fc, addr (A23..A1), d_in -> d_out, d_oe, dtack_n, berr_n;
// memory side mem_req, mem_we, mem_addr, mem_be, mem_wdata <- mem_rdata, mem_ack.
// Optional: define M68K_BUS_SLAVE_BERR_TIMEOUT_EN to build the bus-error
// timeout; otherwise berr_n is tied high and an access waits for mem_ack forever.
module m68k_bus_slave
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
  parameter int unsigned WAIT_STATES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              C100,
  input  logic              reset,
  input  logic              as_n,
  input  logic              rw_n,
  input  logic              uds_n,
  input  logic              lds_n,
  input  logic [FC_W-1:0]   fc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic              dtack_n,
  output logic              berr_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned WAIT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  bus_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              armed;  // AS seen high since the last accepted access
  logic              as_s, rw_s, uds_s, lds_s;

  // Strobe synchronizers
  m68k_sync2 u_sync_as  (.clk(C100), .reset(reset), .d(as_n),  .q(as_s));
  m68k_sync2 u_sync_rw  (.clk(C100), .reset(reset), .d(rw_n),  .q(rw_s));
  m68k_sync2 u_sync_uds (.clk(C100), .reset(reset), .d(uds_n), .q(uds_s));
  m68k_sync2 u_sync_lds (.clk(C100), .reset(reset), .d(lds_n), .q(lds_s));

`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            berr_q;
  logic            to_expired;

  assign to_expired = (to_cnt == TO_LAST);
  assign berr_n     = berr_q;

  // Function code is not decoded by this slave.
  logic unused_ok;
  assign unused_ok = ^fc;
`else
  assign berr_n = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{fc, 32'(TIMEOUT_CYCLES)};
`endif

  // Bus handshake FSM with registered outputs
  always_ff @(posedge C100) begin
    if (reset) begin
      state     <= ST_IDLE;
      dtack_n   <= 1'b1;
      d_oe      <= 1'b0;
      d_out     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      armed     <= 1'b0;
`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
      to_cnt    <= '0;
      berr_q    <= 1'b1;
`endif
    end else begin
      if (as_s) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!as_s && armed && any_strobe(uds_s, lds_s)) begin
            armed <= 1'b0;
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (as_s) begin
            state <= ST_IDLE;
          end else if (addr_hit(addr, BASE_ADDR, ADDR_MASK)) begin
            mem_addr  <= addr;
            mem_we    <= ~rw_s;
            mem_be    <= strobe_be(uds_s, lds_s);
            mem_wdata <= d_in;
            mem_req   <= 1'b1;
            state     <= ST_ACCESS;
`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end else begin
            // Not our window: stay silent until AS goes high again.
            state <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (as_s) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end else if (mem_ack) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            if (!mem_we) begin
              d_out <= mem_rdata;
              d_oe  <= 1'b1;
            end
            if (WAIT_STATES == 0) begin
              dtack_n <= 1'b0;
              state   <= ST_ACK;
            end else begin
              state <= ST_WAIT;
            end
          end
`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
          else if (to_expired) begin
            mem_req <= 1'b0;
            berr_q  <= 1'b0;
            state   <= ST_BERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        ST_WAIT: begin
          if (as_s) begin
            d_oe  <= 1'b0;
            state <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            dtack_n <= 1'b0;
            state   <= ST_ACK;
          end
`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
          else if (to_expired) begin
            d_oe   <= 1'b0;
            berr_q <= 1'b0;
            state  <= ST_BERR;
          end
`endif
          else begin
            wait_cnt <= wait_cnt + 1'b1;
`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
            to_cnt   <= to_cnt + 1'b1;
`endif
          end
        end

        ST_ACK: begin
          if (as_s) begin
            dtack_n <= 1'b1;
            d_oe    <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        ST_BERR: begin
          if (as_s) begin
`ifdef M68K_BUS_SLAVE_BERR_TIMEOUT_EN
            berr_q <= 1'b1;
`endif
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
